lcd_text_writer: RTL and testbench

- Downstream consumer of the SIM reader's 160-bit text output (20 ASCII chars per line, line chosen by the 2-bit DatoW select).
- Initialises a 20x4 HD44780-compatible character LCD in 8-bit write-only mode.
- On each start request, steps DatoW through 0..3, snapshots each 160-bit line and writes it to the matching display row.
- Signals completion to the top level.

---
 rtl/lcd_pkg.sv | 50 +++++
 rtl/lcd_write_cycle.sv | 106 ++++++++++
 rtl/lcd_text_writer.sv | 189 ++++++++++++++++++
 tb/tb_lcd_text_writer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 20x4 text writer: command bytes,
// row base addresses, FSM encodings and small lookup helpers.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] SET_DDRAM     = 8'h80;

  localparam int unsigned N_INIT  = 6;
  localparam int unsigned N_CHARS = 20;
  localparam int unsigned N_LINES = 4;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SETTLE,
    S_ADDR,
    S_CHAR
  } lcd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_PULSE,
    W_WAIT
  } wr_state_e;

  function automatic logic [7:0] init_cmd(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd1, 5'd2: return FUNC_SET_8B2L;
      5'd3:             return DISP_ON;
      5'd4:             return CLEAR;
      default:          return ENTRY_INC;
    endcase
  endfunction

  // DDRAM start address of each visible row on a 20x4 module
  function automatic logic [7:0] row_base(input logic [1:0] line);
    case (line)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One LCD bus write: set RS/DB, strobe E for T_EPW cycles, then hold off
// for the command execution time (longer after CLEAR) and pulse done.
module lcd_write_cycle
  import lcd_pkg::*;
#(
  parameter int unsigned T_EPW = 12,
  parameter int unsigned T_CMD = 2500,
  parameter int unsigned T_CLR = 82000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  output logic       e_o,
  output logic       rs_o,
  output logic [7:0] db_o,
  output logic       done_o
);

  localparam int unsigned MAX_A = (T_EPW > T_CMD) ? T_EPW : T_CMD;
  localparam int unsigned MAX_T = (MAX_A > T_CLR) ? MAX_A : T_CLR;
  localparam int unsigned CNT_W = $clog2(MAX_T + 1);

  wr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] wait_last;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= W_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign wait_last = clr_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);

  // RS/DB only change on a new start, so they stay put through E and beyond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    clr_d   = clr_q;
    done_d  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (start_i) begin
          rs_d    = rs_i;
          db_d    = byte_i;
          clr_d   = !rs_i && (byte_i == CLEAR);
          state_d = W_SETUP;
        end
      end
      W_SETUP: begin
        e_d     = 1'b1;
        cnt_d   = '0;
        state_d = W_PULSE;
      end
      W_PULSE: begin
        if (cnt_q == CNT_W'(T_EPW - 1)) begin
          e_d     = 1'b0;
          cnt_d   = '0;
          state_d = W_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      W_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = W_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign e_o    = e_q;
  assign rs_o   = rs_q;
  assign db_o   = db_q;
  assign done_o = done_q;

endmodule

// File: rtl/lcd_text_writer.sv
// Initialises a 20x4 HD44780 LCD in 8-bit mode, then on each Inicio rising
// edge copies the four 20-character text lines selected by DatoW to the display.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_EPW   = 12,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Inicio,
  input  logic [159:0] Dato_LCD,
  output logic [1:0]   DatoW,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic [7:0]   LCD_DB,
  output logic         Ocupado,
  output logic         Listo
);

  localparam int unsigned CNT_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [1:0]       line_q, line_d;
  logic [159:0]     text_q, text_d;
  logic             pend_q, pend_d;
  logic             ocup_q, ocup_d;
  logic             listo_q, listo_d;
  logic             in_q, in_prev_q;
  logic             in_rise;

  logic             wr_start;
  logic             wr_rs;
  logic [7:0]       wr_byte;
  logic             wr_done;

  function automatic logic [7:0] char_at(input logic [159:0] text, input logic [4:0] idx);
    logic [7:0] c;
    c = 8'h20;
    for (int k = 0; k < int'(N_CHARS); k++) begin
      if (idx == 5'(k)) c = text[159 - 8*k -: 8];
    end
    return c;
  endfunction

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= S_PWRUP;
      cnt_q     <= '0;
      idx_q     <= '0;
      line_q    <= '0;
      text_q    <= '0;
      pend_q    <= 1'b0;
      ocup_q    <= 1'b1;
      listo_q   <= 1'b0;
      in_q      <= 1'b0;
      in_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      text_q    <= text_d;
      pend_q    <= pend_d;
      ocup_q    <= ocup_d;
      listo_q   <= listo_d;
      in_q      <= Inicio;
      in_prev_q <= in_q;
    end
  end

  // Edge is tracked in every state, so a level held through a pass never re-triggers
  assign in_rise = in_q && !in_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    line_d   = line_q;
    text_d   = text_q;
    pend_d   = pend_q;
    ocup_d   = ocup_q;
    listo_d  = 1'b0;
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_byte  = 8'h00;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CNT_W'(T_PWRUP - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INIT: begin
        wr_byte  = init_cmd(idx_q);
        wr_start = !pend_q;
        if (!pend_q) begin
          pend_d = 1'b1;
        end else if (wr_done) begin
          pend_d = 1'b0;
          if (idx_q == 5'(N_INIT - 1)) begin
            idx_d   = '0;
            ocup_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_IDLE: begin
        if (in_rise) begin
          ocup_d  = 1'b1;
          line_d  = 2'd0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        text_d  = Dato_LCD;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        wr_byte  = SET_DDRAM | row_base(line_q);
        wr_start = !pend_q;
        if (!pend_q) begin
          pend_d = 1'b1;
        end else if (wr_done) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = S_CHAR;
        end
      end
      S_CHAR: begin
        wr_rs    = 1'b1;
        wr_byte  = char_at(text_q, idx_q);
        wr_start = !pend_q;
        if (!pend_q) begin
          pend_d = 1'b1;
        end else if (wr_done) begin
          pend_d = 1'b0;
          if (idx_q == 5'(N_CHARS - 1)) begin
            idx_d = '0;
            if (line_q == 2'(N_LINES - 1)) begin
              listo_d = 1'b1;
              ocup_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              line_d  = line_q + 2'd1;
              state_d = S_SETTLE;
            end
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  lcd_write_cycle #(
    .T_EPW (T_EPW),
    .T_CMD (T_CMD),
    .T_CLR (T_CLR)
  ) u_wr (
    .clk_i   (CLK),
    .rst_ni  (Reset),
    .start_i (wr_start),
    .rs_i    (wr_rs),
    .byte_i  (wr_byte),
    .e_o     (LCD_E),
    .rs_o    (LCD_RS),
    .db_o    (LCD_DB),
    .done_o  (wr_done)
  );

  assign LCD_RW  = 1'b0;
  assign DatoW   = line_q;
  assign Ocupado = ocup_q;
  assign Listo   = listo_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: captures every LCD bus write on the E falling
// edge and compares against init/pass sequences built from the text lines.
module tb_lcd_text_writer;

  localparam int T_PWRUP = 20;
  localparam int T_EPW   = 2;
  localparam int T_CMD   = 5;
  localparam int T_CLR   = 10;

  logic         CLK = 1'b0;
  logic         Reset = 1'b0;
  logic         Inicio = 1'b0;
  logic [159:0] Dato_LCD;
  logic [1:0]   DatoW;
  logic         LCD_E, LCD_RS, LCD_RW;
  logic [7:0]   LCD_DB;
  logic         Ocupado, Listo;

  logic [159:0] lines [4];
  logic [159:0] snap  [4];
  logic [7:0]   init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [7:0]   row_addr [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

  assign Dato_LCD = lines[DatoW];

  lcd_text_writer #(
    .T_PWRUP (T_PWRUP),
    .T_EPW   (T_EPW),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Inicio   (Inicio),
    .Dato_LCD (Dato_LCD),
    .DatoW    (DatoW),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_DB   (LCD_DB),
    .Ocupado  (Ocupado),
    .Listo    (Listo)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [10:0] wr_q [$];
  logic [10:0] exp_q [$];
  int          hi_q [$];
  int          gap_q [$];
  int          low_cnt = 0, hi_cnt = 0, since_fall = 0, stable_err = 0;
  int          listo_pulses = 0, listo_cycles = 0;
  logic        ocup_after_listo = 1'b1;
  logic        e_prev = 1'b0, listo_prev = 1'b0;
  logic [8:0]  rise_db = 9'h000;

  // Bus monitor: one record {DatoW, RS, DB} per completed E pulse
  initial forever begin
    @(negedge CLK);
    if (LCD_E && !e_prev) begin
      gap_q.push_back(low_cnt);
      hi_cnt = 1;
      rise_db = {LCD_RS, LCD_DB};
    end else if (LCD_E) begin
      hi_cnt++;
    end
    if (!LCD_E && e_prev) begin
      wr_q.push_back({DatoW, LCD_RS, LCD_DB});
      hi_q.push_back(hi_cnt);
      if ({LCD_RS, LCD_DB} !== rise_db) stable_err++;
      low_cnt = 0;
      since_fall = 0;
    end else if (!LCD_E) begin
      low_cnt++;
      since_fall++;
    end
    if (Listo) listo_cycles++;
    if (Listo && !listo_prev) listo_pulses++;
    if (listo_prev && !Listo) ocup_after_listo = Ocupado;
    e_prev = LCD_E;
    listo_prev = Listo;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    hi_q.delete();
    gap_q.delete();
    stable_err = 0;
    ocup_after_listo = 1'b1;
  endtask

  task automatic fill_lines();
    lines[0] = "Nombre: JUAN PEREZ  ";
    for (int l = 1; l < 4; l++)
      for (int k = 0; k < 20; k++)
        lines[l][159-8*k -: 8] = 8'($urandom_range(32, 126));
  endtask

  // Reference pass: per line, the row address command then its 20 chars in order
  task automatic build_expected();
    exp_q.delete();
    for (int l = 0; l < 4; l++) begin
      exp_q.push_back({2'(l), 1'b0, row_addr[l]});
      for (int k = 0; k < 20; k++)
        exp_q.push_back({2'(l), 1'b1, snap[l][159-8*k -: 8]});
    end
  endtask

  task automatic wait_listo(input int budget, output bit ok);
    int n0 = listo_pulses;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (listo_pulses != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int e_seen = 0, ocup_low = 0;
    Reset = 1'b0;
    Inicio = 1'b0;
    fill_lines();
    tick(3);
    checks++;
    if ({LCD_E, LCD_RS, LCD_RW, LCD_DB} !== 11'h000) begin
      failures++;
      $display("FAIL reset_bus actual=%h required=000", {LCD_E, LCD_RS, LCD_RW, LCD_DB});
    end
    checks++;
    if ({DatoW, Ocupado, Listo} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=0010", {DatoW, Ocupado, Listo});
    end
    clear_mon();
    Reset = 1'b1;
    for (int i = 0; i < T_PWRUP; i++) begin
      tick(1);
      if (LCD_E) e_seen++;
      if (!Ocupado) ocup_low++;
    end
    checks++;
    if (e_seen != 0 || ocup_low != 0) begin
      failures++;
      $display("FAIL pwrup_quiet actual e_high=%0d ocup_low=%0d required 0 0", e_seen, ocup_low);
    end
  endtask

  task automatic test_init();
    bit ok = 1'b0;
    int sf = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (!Ocupado) begin
        ok = 1'b1;
        sf = since_fall;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL init_timeout actual=busy required=idle");
    end
    checks++;
    if (wr_q.size() != 6) begin
      failures++;
      $display("FAIL init_count actual=%0d required=6", wr_q.size());
    end
    for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== {2'b00, 1'b0, init_seq[i]}) begin
        failures++;
        $display("FAIL init_byte%0d actual=%h required=%h", i, wr_q[i], {2'b00, 1'b0, init_seq[i]});
      end
    end
    if (gap_q.size() >= 6) begin
      checks++;
      if (gap_q[5] < T_CLR) begin
        failures++;
        $display("FAIL clear_wait actual=%0d required>=%0d", gap_q[5], T_CLR);
      end
    end
    checks++;
    if (sf < T_CMD) begin
      failures++;
      $display("FAIL ocup_after_wait actual=%0d required>=%0d", sf, T_CMD);
    end
    checks++;
    if (stable_err != 0) begin
      failures++;
      $display("FAIL init_db_stable actual=%0d required=0", stable_err);
    end
  endtask

  task automatic test_pass();
    bit ok;
    int n0 = listo_pulses, c0 = listo_cycles, bad_w = 0, bad_g = 0;
    snap = lines;
    build_expected();
    clear_mon();
    Inicio = 1'b1;
    tick(3);
    Inicio = 1'b0;
    wait_listo(3000, ok);
    tick(3);
    checks++;
    if (!ok || wr_q.size() != 84) begin
      failures++;
      $display("FAIL pass_count actual=%0d done=%0d required=84 done=1", wr_q.size(), ok);
    end
    for (int i = 0; i < 84 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL pass_w%0d actual=%h required=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wr_q.size() > 9 && (wr_q[1][8:0] !== 9'h14E || wr_q[9][8:0] !== 9'h14A)) begin
      failures++;
      $display("FAIL pass_name actual=%h,%h required=14e,14a", wr_q[1][8:0], wr_q[9][8:0]);
    end
    foreach (hi_q[i]) if (hi_q[i] != T_EPW) bad_w++;
    foreach (gap_q[i]) if (gap_q[i] < T_CMD) bad_g++;
    checks++;
    if (bad_w != 0 || bad_g != 0 || stable_err != 0) begin
      failures++;
      $display("FAIL pass_timing actual bad_width=%0d bad_gap=%0d unstable=%0d required 0", bad_w, bad_g, stable_err);
    end
    checks++;
    if (listo_pulses != n0 + 1 || listo_cycles != c0 + 1) begin
      failures++;
      $display("FAIL listo_pulse actual pulses=%0d cycles=%0d required 1 1", listo_pulses - n0, listo_cycles - c0);
    end
    checks++;
    if (ocup_after_listo !== 1'b0 || Ocupado !== 1'b0) begin
      failures++;
      $display("FAIL ocup_end actual=%b%b required=00", ocup_after_listo, Ocupado);
    end
  endtask

  task automatic test_held();
    bit ok;
    int n0 = listo_pulses;
    fill_lines();
    snap = lines;
    build_expected();
    clear_mon();
    Inicio = 1'b1;
    tick(500);
    checks++;
    if (Ocupado !== 1'b1) begin
      failures++;
      $display("FAIL held_busy actual=%b required=1", Ocupado);
    end
    Inicio = 1'b0;
    tick(3);
    Inicio = 1'b1;
    wait_listo(3000, ok);
    tick(300);
    checks++;
    if (!ok || wr_q.size() != 84 || listo_pulses != n0 + 1) begin
      failures++;
      $display("FAIL held_single actual writes=%0d passes=%0d required 84 1", wr_q.size(), listo_pulses - n0);
    end
    for (int i = 0; i < 84 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL held_w%0d actual=%h required=%h", i, wr_q[i], exp_q[i]);
      end
    end
    Inicio = 1'b0;
  endtask

  task automatic test_snapshot();
    bit ok, seen = 1'b0;
    tick(3);
    fill_lines();
    snap = lines;
    build_expected();
    clear_mon();
    Inicio = 1'b1;
    tick(2);
    Inicio = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (DatoW == 2'd1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL snap_line1 actual=%0d required=1", DatoW);
    end
    tick(4);
    lines[1] = lines[1] ^ {20{8'h01}};
    wait_listo(3000, ok);
    tick(3);
    checks++;
    if (!ok || wr_q.size() != 84) begin
      failures++;
      $display("FAIL snap_count actual=%0d required=84", wr_q.size());
    end
    for (int i = 21; i < 42 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL snap_w%0d actual=%h required=%h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int p0;
    fill_lines();
    Inicio = 1'b1;
    tick(2);
    Inicio = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (DatoW == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_line2 actual=%0d required=2", DatoW);
    end
    tick(30);
    p0 = listo_pulses;
    Reset = 1'b0;
    tick(1);
    checks++;
    if ({LCD_E, LCD_DB, DatoW, Ocupado, Listo} !== {1'b0, 8'h00, 2'b00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset actual=%h required=%h", {LCD_E, LCD_DB, DatoW, Ocupado, Listo},
               {1'b0, 8'h00, 2'b00, 1'b1, 1'b0});
    end
    Reset = 1'b1;
    clear_mon();
    test_init();
    checks++;
    if (listo_pulses != p0) begin
      failures++;
      $display("FAIL mid_no_listo actual=%0d required=0", listo_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_pass();
    test_held();
    test_snapshot();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
